// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall/bubble control
// Also keeps the multiply-accumulate partial product and step count across its two cycles.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        ex_whilo,
  input  logic [63:0] hilo_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic [63:0] hilo_o,
  output logic [1:0]  cnt_o
);

  logic [4:0]  wd_q,    wd_d;
  logic        wreg_q,  wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        whilo_q, whilo_d;
  logic [63:0] hilo_q,  hilo_d;
  logic [1:0]  cnt_q,   cnt_d;

  logic ex_stall;
  logic mem_stall;

  assign ex_stall  = stall[3];
  assign mem_stall = stall[4];

  always_comb begin
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    whilo_d = whilo_q;
    hilo_d  = hilo_i;
    cnt_d   = cnt_i;
    if (!ex_stall) begin
      // stall[4] alone cannot come from the controller; it is treated as a normal pass
      wd_d    = ex_wd;
      wreg_d  = ex_wreg;
      wdata_d = ex_wdata;
      hi_d    = ex_hi;
      lo_d    = ex_lo;
      whilo_d = ex_whilo;
      hilo_d  = '0;
      cnt_d   = '0;
    end else if (!mem_stall) begin
      wd_d    = '0;
      wreg_d  = 1'b0;
      wdata_d = '0;
      hi_d    = '0;
      lo_d    = '0;
      whilo_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      whilo_q <= 1'b0;
      hilo_q  <= '0;
      cnt_q   <= '0;
    end else begin
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      whilo_q <= whilo_d;
      hilo_q  <= hilo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign mem_whilo = whilo_q;
  assign hilo_o    = hilo_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - directed self-checking bench for ex_mem
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int errors = 0;
    int checks = 0;

    logic [102:0] mem_all;
    assign mem_all = {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo};

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic [31:0] hi, input logic [31:0] lo, input logic whilo);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
    endtask

    task automatic test_reset;
        logic [102:0] exp_mem;
        rst = 1'b0;
        stall = 6'd0;
        drive(5'd31, 1'b1, 32'hFFFF_0001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        hilo_i = 64'hCAFE_F00D_1357_2468;
        cnt_i = 2'd3;
        #2;
        checks++;
        if ({mem_all, hilo_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_initial: got %h, expected 0", {mem_all, hilo_o, cnt_o});
        end
        step;
        rst = 1'b1;
        step;
        exp_mem = {5'd31, 1'b1, 32'hFFFF_0001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1};
        checks++;
        if (mem_all !== exp_mem) begin
            errors++;
            $display("FAIL reset_first_capture: got %h, expected %h", mem_all, exp_mem);
        end
        stall = 6'b011111;
        step;
        checks++;
        if (hilo_o !== 64'hCAFE_F00D_1357_2468 || cnt_o !== 2'd3) begin
            errors++;
            $display("FAIL reset_pre_hilo: got %h/%0d, expected cafef00d13572468/3", hilo_o, cnt_o);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_all, hilo_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_async_midstall: got %h, expected 0", {mem_all, hilo_o, cnt_o});
        end
        step;
        checks++;
        if ({mem_all, hilo_o, cnt_o} !== '0) begin
            errors++;
            $display("FAIL reset_held: got %h, expected 0", {mem_all, hilo_o, cnt_o});
        end
        #2;
        rst = 1'b1;
        stall = 6'd0;
        step;
    endtask

    task automatic test_pass;
        logic [102:0] exp_mem;
        stall = 6'd0;
        drive(5'd7, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1);
        hilo_i = 64'h1111_2222_3333_4444;
        cnt_i = 2'd2;
        step;
        exp_mem = {5'd7, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h2, 1'b1};
        checks++;
        if (mem_all !== exp_mem) begin
            errors++;
            $display("FAIL pass_mem: got %h, expected %h", mem_all, exp_mem);
        end
        checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL pass_hilo_clear: got %h/%0d, expected 0/0", hilo_o, cnt_o);
        end
    endtask

    task automatic test_bubble;
        stall = 6'b001111;
        hilo_i = 64'h0000_0003_0000_0004;
        cnt_i = 2'd1;
        step;
        checks++;
        if (mem_all !== '0) begin
            errors++;
            $display("FAIL bubble_mem: got %h, expected 0", mem_all);
        end
        checks++;
        if (hilo_o !== 64'h0000_0003_0000_0004 || cnt_o !== 2'd1) begin
            errors++;
            $display("FAIL bubble_hilo: got %h/%0d, expected 0000000300000004/1", hilo_o, cnt_o);
        end
        drive(5'd9, 1'b1, 32'h7777_7777, 32'h5, 32'h6, 1'b1);
        hilo_i = 64'h8000_0000_0000_0001;
        cnt_i = 2'd2;
        step;
        checks++;
        if (mem_all !== '0 || hilo_o !== 64'h8000_0000_0000_0001 || cnt_o !== 2'd2) begin
            errors++;
            $display("FAIL bubble_second: got %h %h/%0d, expected 0 8000000000000001/2", mem_all, hilo_o, cnt_o);
        end
    endtask

    task automatic test_hold;
        logic [102:0] exp_mem;
        logic [63:0] h;
        stall = 6'd0;
        drive(5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b0);
        step;
        exp_mem = {5'd3, 1'b1, 32'hA5A5_A5A5, 32'h11, 32'h22, 1'b0};
        checks++;
        if (mem_all !== exp_mem) begin
            errors++;
            $display("FAIL hold_load: got %h, expected %h", mem_all, exp_mem);
        end
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            drive(5'(i + 20), 1'b0, 32'h1000_0000 + i, 32'hF0 + i, 32'hE0 + i, 1'b1);
            h = 64'hABCD_0000_0000_0000 + 64'(i);
            hilo_i = h;
            cnt_i = 2'(i + 1);
            step;
            checks++;
            if (mem_all !== exp_mem) begin
                errors++;
                $display("FAIL hold_mem_%0d: got %h, expected %h", i, mem_all, exp_mem);
            end
            checks++;
            if (hilo_o !== h || cnt_o !== 2'(i + 1)) begin
                errors++;
                $display("FAIL hold_hilo_%0d: got %h/%0d, expected %h/%0d", i, hilo_o, cnt_o, h, i + 1);
            end
        end
        stall = 6'd0;
        drive(5'd30, 1'b1, 32'h0BAD_F00D, 32'h3333, 32'h4444, 1'b1);
        step;
        exp_mem = {5'd30, 1'b1, 32'h0BAD_F00D, 32'h3333, 32'h4444, 1'b1};
        checks++;
        if (mem_all !== exp_mem || hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL hold_release: got %h %h/%0d, expected %h 0/0", mem_all, hilo_o, cnt_o, exp_mem);
        end
    endtask

    task automatic test_madd;
        logic [102:0] exp_mem;
        stall = 6'b001111;
        drive(5'd0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        hilo_i = 64'h0123_4567_89AB_CDEF;
        cnt_i = 2'd1;
        step;
        checks++;
        if (hilo_o !== 64'h0123_4567_89AB_CDEF || cnt_o !== 2'd1) begin
            errors++;
            $display("FAIL madd_cycle2: got %h/%0d, expected 0123456789abcdef/1", hilo_o, cnt_o);
        end
        stall = 6'd0;
        drive(5'd0, 1'b0, 32'd0, 32'h0123_4568, 32'h89AB_CDEE, 1'b1);
        hilo_i = 64'h5555_5555_5555_5555;
        cnt_i = 2'd2;
        step;
        exp_mem = {5'd0, 1'b0, 32'd0, 32'h0123_4568, 32'h89AB_CDEE, 1'b1};
        checks++;
        if (mem_all !== exp_mem) begin
            errors++;
            $display("FAIL madd_result: got %h, expected %h", mem_all, exp_mem);
        end
        checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL madd_clear: got %h/%0d, expected 0/0", hilo_o, cnt_o);
        end
    endtask

    task automatic test_illegal;
        logic [102:0] exp_mem;
        stall = 6'b001111;
        hilo_i = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt_i = 2'd3;
        step;
        stall = 6'b010000;
        drive(5'd17, 1'b1, 32'h8000_0001, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0);
        step;
        exp_mem = {5'd17, 1'b1, 32'h8000_0001, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0};
        checks++;
        if (mem_all !== exp_mem) begin
            errors++;
            $display("FAIL illegal_mem: got %h, expected %h", mem_all, exp_mem);
        end
        checks++;
        if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL illegal_hilo: got %h/%0d, expected 0/0", hilo_o, cnt_o);
        end
    endtask

    initial begin
        test_reset;
        test_pass;
        test_bubble;
        test_hold;
        test_madd;
        test_illegal;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
